// File: rtl/axi_l2_print_eoc_ctrl.sv
// axi_l2_print_eoc_ctrl: passive AXI write snoop; decodes stdout/stderr/EOC
// mailbox writes into registered one-cycle event pulses.
// Ports: clk_i, rst_ni; AW snoop (aw_valid_i, aw_ready_i, aw_addr_i,
// aw_len_i); W snoop (w_valid_i, w_ready_i, w_data_i, w_last_i);
// events stdout_valid_o/stdout_char_o, stderr_valid_o/stderr_code_o,
// eoc_valid_o/exit_code_o; sticky done_o, overflow_o, proto_err_o.
// Option: define AXI_L2_PRINT_DISPLAY_EN to echo events via $write/$display.
module axi_l2_print_eoc_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] STDERR_ADDR = 32'h2FFF_0000,
  parameter logic [ADDR_W-1:0] STDOUT_ADDR = 32'h2FFF_0004,
  parameter logic [ADDR_W-1:0] EOC_ADDR    = 32'h2C03_0000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              aw_valid_i,
  input  logic              aw_ready_i,
  input  logic [ADDR_W-1:0] aw_addr_i,
  input  logic [7:0]        aw_len_i,
  input  logic              w_valid_i,
  input  logic              w_ready_i,
  input  logic [DATA_W-1:0] w_data_i,
  input  logic              w_last_i,
  output logic              stdout_valid_o,
  output logic [7:0]        stdout_char_o,
  output logic              stderr_valid_o,
  output logic [7:0]        stderr_code_o,
  output logic              eoc_valid_o,
  output logic [31:0]       exit_code_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic              proto_err_o
);

  localparam int LB = $clog2(DATA_W/8);
  localparam int NW = DATA_W/32;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    CL_OTHER, CL_STDOUT, CL_STDERR, CL_EOC
  } cls_e;

  typedef enum logic {IDLE, BURST} state_e;

  typedef struct packed {
    cls_e          cls;
    logic [IW-1:0] idx;
    logic [7:0]    len;
  } ent_t;

  ent_t        mem [DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  state_e      state, state_n;
  logic [7:0]  cnt, cnt_n;

  logic aw_hs, w_hs, empty, full;
  logic bypass, beat, first, last;
  logic push_req, push, pop;
  logic ovf_set, perr_set;
  logic so_fire, se_fire, eoc_fire;
  logic [IW-1:0] aw_idx;
  logic [31:0]   word;
  ent_t in_ent, cur;

  assign aw_hs = aw_valid_i & aw_ready_i;
  assign w_hs  = w_valid_i & w_ready_i;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0])
               & (wr_ptr[PW] != rd_ptr[PW]);

  if (NW > 1) begin : g_idx
    assign aw_idx = aw_addr_i[LB-1:2];
  end else begin : g_noidx
    assign aw_idx = '0;
  end

  always_comb begin
    in_ent.cls = CL_OTHER;
    in_ent.idx = aw_idx;
    in_ent.len = aw_len_i;
    unique case (1'b1)
      (aw_addr_i == STDOUT_ADDR): in_ent.cls = CL_STDOUT;
      (aw_addr_i == STDERR_ADDR): in_ent.cls = CL_STDERR;
      (aw_addr_i == EOC_ADDR):    in_ent.cls = CL_EOC;
      default:                    in_ent.cls = CL_OTHER;
    endcase
  end

  // Empty FIFO plus same-cycle AW/W: the beat rides the incoming AW.
  assign bypass = empty & aw_hs & w_hs;
  assign cur    = bypass ? in_ent : mem[rd_ptr[PW-1:0]];
  assign beat   = w_hs & (~empty | aw_hs);
  assign first  = (state == IDLE);
  assign last   = first ? (cur.len == 8'd0) : (cnt == cur.len);

  assign pop      = beat & last & ~bypass;
  assign push_req = aw_hs & ~(bypass & (in_ent.len == 8'd0));
  assign push     = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;
  assign perr_set = (w_hs & empty & ~aw_hs)
                  | (beat & (w_last_i != last));

  always_comb begin
    word = '0;
    for (int i = 0; i < NW; i++)
      if (cur.idx == IW'(i)) word = w_data_i[i*32 +: 32];
  end

  assign so_fire  = beat & first & (cur.cls == CL_STDOUT)
                  & (word[7:0] != 8'd0);
  assign se_fire  = beat & first & (cur.cls == CL_STDERR)
                  & (word[7:0] != 8'd0);
  assign eoc_fire = beat & first & (cur.cls == CL_EOC)
                  & (word != 32'd0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (beat) begin
      unique case (state)
        IDLE: begin
          if (cur.len != 8'd0) begin
            state_n = BURST;
            cnt_n   = 8'd1;
          end
        end
        BURST: begin
          if (cnt == cur.len) begin
            state_n = IDLE;
            cnt_n   = 8'd0;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[PW-1:0]] <= in_ent;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stdout_valid_o <= 1'b0;
      stdout_char_o  <= 8'd0;
      stderr_valid_o <= 1'b0;
      stderr_code_o  <= 8'd0;
      eoc_valid_o    <= 1'b0;
      exit_code_o    <= 32'd0;
      done_o         <= 1'b0;
      overflow_o     <= 1'b0;
      proto_err_o    <= 1'b0;
    end else begin
      stdout_valid_o <= so_fire;
      stderr_valid_o <= se_fire;
      eoc_valid_o    <= eoc_fire;
      if (so_fire)  stdout_char_o <= word[7:0];
      if (se_fire)  stderr_code_o <= word[7:0];
      if (eoc_fire) begin
        exit_code_o <= word;
        done_o      <= 1'b1;
      end
      if (ovf_set)  overflow_o  <= 1'b1;
      if (perr_set) proto_err_o <= 1'b1;
    end
  end

`ifdef AXI_L2_PRINT_DISPLAY_EN
  always @(posedge clk_i) begin
    if (stdout_valid_o) $write("%c", stdout_char_o);
    if (stderr_valid_o) $display("stderr code %0d", stderr_code_o);
    if (eoc_valid_o)    $display("exit code %0d", exit_code_o);
  end
`endif

endmodule

// File: tb/tb_axi_l2_print_eoc_ctrl.sv
// tb_axi_l2_print_eoc_ctrl: table-driven self-checking bench with a
// per-cycle expectation queue for axi_l2_print_eoc_ctrl.
module tb_axi_l2_print_eoc_ctrl;

  localparam logic [31:0] SE = 32'h2FFF_0000;
  localparam logic [31:0] SO = 32'h2FFF_0004;
  localparam logic [31:0] EO = 32'h2C03_0000;
  localparam logic [31:0] OT = 32'h1000_0000;
  localparam int NONE = 0;
  localparam int OUT  = 1;
  localparam int ERR  = 2;
  localparam int EOC  = 3;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        aw_valid = 0, aw_ready = 0;
  logic [31:0] aw_addr = 0;
  logic [7:0]  aw_len = 0;
  logic        w_valid = 0, w_ready = 0;
  logic [31:0] w_data = 0;
  logic        w_last = 0;
  logic        stdout_valid, stderr_valid, eoc_valid;
  logic [7:0]  stdout_char, stderr_code;
  logic [31:0] exit_code;
  logic        done, overflow, proto_err;

  axi_l2_print_eoc_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .aw_valid_i(aw_valid), .aw_ready_i(aw_ready),
    .aw_addr_i(aw_addr), .aw_len_i(aw_len),
    .w_valid_i(w_valid), .w_ready_i(w_ready),
    .w_data_i(w_data), .w_last_i(w_last),
    .stdout_valid_o(stdout_valid), .stdout_char_o(stdout_char),
    .stderr_valid_o(stderr_valid), .stderr_code_o(stderr_code),
    .eoc_valid_o(eoc_valid), .exit_code_o(exit_code),
    .done_o(done), .overflow_o(overflow), .proto_err_o(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          awv, awr;
    logic [31:0] addr;
    logic [7:0]  len;
    bit          wv, wr;
    logic [31:0] data;
    bit          wl;
    int          ev;
    logic [31:0] val;
    bit          perr, ovf;
  } vec_t;

  typedef struct {
    int          ev;
    logic [31:0] val;
    logic [31:0] exitc;
    bit          done, perr, ovf;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  logic [31:0] m_exit;
  bit m_done, m_perr, m_ovf;

  function automatic vec_t mk(bit rst, bit awv, logic [31:0] a,
                              logic [7:0] l, bit wv, logic [31:0] d,
                              bit wl, int ev, logic [31:0] val,
                              bit perr, bit ovf);
    vec_t v;
    v.rst = rst; v.awv = awv; v.awr = 1; v.addr = a; v.len = l;
    v.wv = wv; v.wr = 1; v.data = d; v.wl = wl;
    v.ev = ev; v.val = val; v.perr = perr; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, x, $time);
    end
  endtask

  task automatic idle_inputs();
    aw_valid = 0; aw_ready = 0; aw_addr = 0; aw_len = 0;
    w_valid = 0; w_ready = 0; w_data = 0; w_last = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    #2;
    chk("rst_stdout_valid", 32'(stdout_valid), 0);
    chk("rst_stderr_valid", 32'(stderr_valid), 0);
    chk("rst_eoc_valid", 32'(eoc_valid), 0);
    chk("rst_exit_code", exit_code, 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_proto_err", 32'(proto_err), 0);
    m_exit = 0; m_done = 0; m_perr = 0; m_ovf = 0;
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("stdout_valid", 32'(stdout_valid), 32'(e.ev == OUT));
    chk("stderr_valid", 32'(stderr_valid), 32'(e.ev == ERR));
    chk("eoc_valid", 32'(eoc_valid), 32'(e.ev == EOC));
    if (e.ev == OUT) chk("stdout_char", 32'(stdout_char), 32'(e.val[7:0]));
    if (e.ev == ERR) chk("stderr_code", 32'(stderr_code), 32'(e.val[7:0]));
    chk("exit_code", exit_code, e.exitc);
    chk("done", 32'(done), 32'(e.done));
    chk("proto_err", 32'(proto_err), 32'(e.perr));
    chk("overflow", 32'(overflow), 32'(e.ovf));
  endtask

  task automatic step(vec_t v);
    exp_t e;
    if (v.rst) do_reset();
    aw_valid = v.awv; aw_ready = v.awr;
    aw_addr = v.addr; aw_len = v.len;
    w_valid = v.wv; w_ready = v.wr;
    w_data = v.data; w_last = v.wl;
    @(posedge clk);
    if (v.ev == EOC) begin
      m_exit = v.val;
      m_done = 1;
    end
    m_perr = m_perr | v.perr;
    m_ovf = m_ovf | v.ovf;
    e.ev = v.ev; e.val = v.val; e.exitc = m_exit;
    e.done = m_done; e.perr = m_perr; e.ovf = m_ovf;
    sb.push_back(e);
    #1;
    check_out();
    idle_inputs();
  endtask

  initial begin
    vec_t v;
    m_exit = 0; m_done = 0; m_perr = 0; m_ovf = 0;
    // single char, then interleaved bursts
    tbl.push_back(mk(0,1,SO,0, 0,0,0, NONE,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h48,1, OUT,32'h48,0,0));
    tbl.push_back(mk(0,1,OT,3, 0,0,0, NONE,0,0,0));
    tbl.push_back(mk(0,1,SE,0, 0,0,0, NONE,0,0,0));
    tbl.push_back(mk(0,1,SO,0, 1,32'h41,0, NONE,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h05,0, NONE,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h05,0, NONE,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h05,1, NONE,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h05,1, ERR,32'h05,0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h63,1, OUT,32'h63,0,0));
    // bypass with zero byte, bypass EOC, bypass multi-beat
    tbl.push_back(mk(0,1,SO,0, 1,32'h1200,1, NONE,0,0,0));
    tbl.push_back(mk(0,1,EO,0, 1,32'h1,1, EOC,32'h1,0,0));
    tbl.push_back(mk(0,1,SE,1, 1,32'h07,0, ERR,32'h07,0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h09,1, NONE,0,0,0));
    // early w_last on beat 1 of len=2
    tbl.push_back(mk(0,1,SO,2, 0,0,0, NONE,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h21,0, OUT,32'h21,0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h22,1, NONE,0,1,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h23,1, NONE,0,0,0));
    // W valid without ready: no handshake
    v = mk(0,0,0,0, 1,32'h5A,1, NONE,0,0,0);
    v.wr = 0;
    tbl.push_back(v);
    // EOC overwrite, then zero EOC ignored
    tbl.push_back(mk(0,1,EO,0, 0,0,0, NONE,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'hDEAD_0003,1, EOC,32'hDEAD_0003,0,0));
    tbl.push_back(mk(0,1,EO,0, 1,32'h0,1, NONE,0,0,0));
    // after reset: orphan W beat
    tbl.push_back(mk(1,0,0,0, 1,32'h55,1, NONE,0,1,0));
    // fill FIFO, full push+pop, then overflow
    tbl.push_back(mk(1,1,OT,0, 0,0,0, NONE,0,0,0));
    tbl.push_back(mk(0,1,OT,0, 0,0,0, NONE,0,0,0));
    tbl.push_back(mk(0,1,OT,0, 0,0,0, NONE,0,0,0));
    tbl.push_back(mk(0,1,OT,0, 0,0,0, NONE,0,0,0));
    tbl.push_back(mk(0,1,SO,0, 1,32'h0,1, NONE,0,0,0));
    tbl.push_back(mk(0,1,OT,0, 0,0,0, NONE,0,0,1));
    tbl.push_back(mk(0,0,0,0, 1,32'h11,1, NONE,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h12,1, NONE,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h13,1, NONE,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h4F,1, OUT,32'h4F,0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h77,1, NONE,0,1,0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // reset mid-burst: OTHER len=7 interrupted at beat 3
    step(mk(0,1,EO,0, 1,32'h2A,1, EOC,32'h2A,0,0));
    step(mk(0,1,OT,7, 1,32'h0,0, NONE,0,0,0));
    step(mk(0,0,0,0, 1,32'h1,0, NONE,0,0,0));
    step(mk(0,0,0,0, 1,32'h2,0, NONE,0,0,0));
    step(mk(1,1,SO,0, 0,0,0, NONE,0,0,0));
    step(mk(0,0,0,0, 1,32'h41,1, OUT,32'h41,0,0));
    step(mk(0,0,0,0, 0,0,0, NONE,0,0,0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
